partition_sweep_meter: RTL and testbench

//  Exhaustive sweep-and-score stage wrapped around one approximated logic partition.

---
 rtl/partition_sweep_meter.sv | 150 +++++++++++++++
 tb/tb_partition_sweep_meter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/partition_sweep_meter.sv
// Exhaustive sweep of an NI-input logic partition: drives every input vector, compares the
// exact and approximate partition outputs, and accumulates error count, Hamming and absolute-error metrics.
module partition_sweep_meter #(
    parameter int NI  = 7,
    parameter int NO  = 4,
    parameter int LAT = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic [NI-1:0]               pi,
    input  logic [NO-1:0]               po_exact,
    input  logic [NO-1:0]               po_approx,
    output logic                        busy,
    output logic                        done,
    output logic [NI:0]                 err_cnt,
    output logic [NI+$clog2(NO+1)-1:0]  hd_sum,
    output logic [NI+NO-1:0]            aed_sum,
    output logic [$clog2(NO+1)-1:0]     max_hd,
    output logic [NI-1:0]               worst_vec
);
    localparam int N  = 1 << NI;
    localparam int HW = $clog2(NO + 1);
    localparam int DW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [NI-1:0]        pi_reg;
    logic [DW-1:0]        drain_cnt_reg;
    logic [NI:0]          err_cnt_reg;
    logic [NI+HW-1:0]     hd_sum_reg;
    logic [NI+NO-1:0]     aed_sum_reg;
    logic [HW-1:0]        max_hd_reg;
    logic [NI-1:0]        worst_vec_reg;

    logic                 start_accept;
    logic                 last_vec;
    logic                 score_valid;
    logic [NI-1:0]        score_idx;
    logic [NO-1:0]        diff;
    logic [HW-1:0]        hd;
    logic [NO-1:0]        ad;

    assign start_accept = start && (state_reg == IDLE || state_reg == DONE);
    assign last_vec     = (pi_reg == NI'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = SWEEP;
            SWEEP: if (last_vec) state_next = (LAT > 0) ? DRAIN : DONE;
            DRAIN: if (drain_cnt_reg == DW'(LAT - 1)) state_next = DONE;
            DONE:  if (start) state_next = SWEEP;
            default: state_next = IDLE;
        endcase
    end

    // Tag (valid + vector index) travels LAT cycles so scoring lines up with partition latency.
    generate
        if (LAT == 0) begin : g_no_delay
            assign score_valid = (state_reg == SWEEP);
            assign score_idx   = pi_reg;
        end else begin : g_delay
            logic          dl_valid [LAT];
            logic [NI-1:0] dl_idx   [LAT];
            for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            dl_valid[gi] <= 1'b0;
                            dl_idx[gi]   <= '0;
                        end else begin
                            dl_valid[gi] <= (state_reg == SWEEP);
                            dl_idx[gi]   <= pi_reg;
                        end
                    end
                end else begin : g_next
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            dl_valid[gi] <= 1'b0;
                            dl_idx[gi]   <= '0;
                        end else begin
                            dl_valid[gi] <= dl_valid[gi-1];
                            dl_idx[gi]   <= dl_idx[gi-1];
                        end
                    end
                end
            end
            assign score_valid = dl_valid[LAT-1];
            assign score_idx   = dl_idx[LAT-1];
        end
    endgenerate

    always_comb begin
        diff = po_exact ^ po_approx;
        hd   = '0;
        for (int i = 0; i < NO; i++) hd = hd + HW'(diff[i]);
        ad   = (po_exact >= po_approx) ? (po_exact - po_approx) : (po_approx - po_exact);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pi_reg        <= '0;
            drain_cnt_reg <= '0;
            err_cnt_reg   <= '0;
            hd_sum_reg    <= '0;
            aed_sum_reg   <= '0;
            max_hd_reg    <= '0;
            worst_vec_reg <= '0;
        end else begin
            if (start_accept) begin
                pi_reg        <= '0;
                err_cnt_reg   <= '0;
                hd_sum_reg    <= '0;
                aed_sum_reg   <= '0;
                max_hd_reg    <= '0;
                worst_vec_reg <= '0;
            end else begin
                if (state_reg == SWEEP && !last_vec) pi_reg <= pi_reg + 1'b1;
                if (score_valid) begin
                    err_cnt_reg <= err_cnt_reg + (NI+1)'(diff != '0);
                    hd_sum_reg  <= hd_sum_reg + (NI+HW)'(hd);
                    aed_sum_reg <= aed_sum_reg + (NI+NO)'(ad);
                    // Strict compare keeps the earliest vector on ties.
                    if (hd > max_hd_reg) begin
                        max_hd_reg    <= hd;
                        worst_vec_reg <= score_idx;
                    end
                end
            end
            if (state_reg == SWEEP)      drain_cnt_reg <= '0;
            else if (state_reg == DRAIN) drain_cnt_reg <= drain_cnt_reg + 1'b1;
        end
    end

    assign pi        = pi_reg;
    assign busy      = (state_reg == SWEEP) || (state_reg == DRAIN);
    assign done      = (state_reg == DONE);
    assign err_cnt   = err_cnt_reg;
    assign hd_sum    = hd_sum_reg;
    assign aed_sum   = aed_sum_reg;
    assign max_hd    = max_hd_reg;
    assign worst_vec = worst_vec_reg;
endmodule

// File: tb/tb_partition_sweep_meter.sv
// Directed bench: a combinational (LAT=0) and a two-stage pipelined (LAT=2) partition model
// each drive a meter instance; sweep results are checked against hand-computed totals.
module tb_partition_sweep_meter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [1:0] mode = 2'd0;

    logic [6:0]  pi_a, pi_b;
    logic [3:0]  ex_a, ap_a, ex_b, ap_b;
    logic        busy_a, done_a, busy_b, done_b;
    logic [7:0]  err_a, err_b;
    logic [9:0]  hd_a, hd_b;
    logic [10:0] aed_a, aed_b;
    logic [2:0]  mx_a, mx_b;
    logic [6:0]  wv_a, wv_b;
    logic [3:0]  ex_s1, ex_s2, ap_s1, ap_s2;

    int total = 0;
    int bad   = 0;
    int n;

    // mode 0: approx==exact (adder), 1: LSB flipped, 2: exact 0 / approx F at 0x5A only
    function automatic logic [3:0] exact_f(input logic [1:0] m, input logic [6:0] p);
        if (m == 2'd2) return 4'h0;
        return p[3:0] + {1'b0, p[6:4]};
    endfunction

    function automatic logic [3:0] approx_f(input logic [1:0] m, input logic [6:0] p);
        case (m)
            2'd1:    return exact_f(m, p) ^ 4'b0001;
            2'd2:    return (p == 7'h5A) ? 4'hF : 4'h0;
            default: return exact_f(m, p);
        endcase
    endfunction

    assign ex_a = exact_f(mode, pi_a);
    assign ap_a = approx_f(mode, pi_a);

    always @(posedge clk) begin
        ex_s1 <= exact_f(2'd2, pi_b);
        ap_s1 <= approx_f(2'd2, pi_b);
        ex_s2 <= ex_s1;
        ap_s2 <= ap_s1;
    end
    assign ex_b = ex_s2;
    assign ap_b = ap_s2;

    partition_sweep_meter #(.NI(7), .NO(4), .LAT(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pi(pi_a),
        .po_exact(ex_a), .po_approx(ap_a), .busy(busy_a), .done(done_a),
        .err_cnt(err_a), .hd_sum(hd_a), .aed_sum(aed_a), .max_hd(mx_a), .worst_vec(wv_a)
    );

    partition_sweep_meter #(.NI(7), .NO(4), .LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pi(pi_b),
        .po_exact(ex_b), .po_approx(ap_b), .busy(busy_b), .done(done_b),
        .err_cnt(err_b), .hd_sum(hd_b), .aed_sum(aed_b), .max_hd(mx_b), .worst_vec(wv_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(output int cnt);
        cnt = 0;
        while (done_a !== 1'b1 && cnt < 400) begin
            tick();
            cnt++;
        end
    endtask

    task automatic chk_a(input string t, input int e, input int h, input int a, input int m, input int w);
        chk({t, "_err"}, 32'(err_a), 32'(e));
        chk({t, "_hd"},  32'(hd_a),  32'(h));
        chk({t, "_aed"}, 32'(aed_a), 32'(a));
        chk({t, "_max"}, 32'(mx_a),  32'(m));
        chk({t, "_wv"},  32'(wv_a),  32'(w));
    endtask

    initial begin
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_pi",   32'(pi_a),   32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        chk_a("rst", 0, 0, 0, 0, 0);
        chk("rst_b_busy", 32'(busy_b), 32'h0);

        // T1: exact match
        mode = 2'd0;
        pulse_a();
        chk("t1_busy", 32'(busy_a), 32'h1);
        chk("t1_pi0",  32'(pi_a),   32'h0);
        tick();
        chk("t1_pi1",  32'(pi_a),   32'h1);
        wait_done_a(n);
        chk("t1_lat",  32'(n + 1),  32'd128);
        chk("t1_busy_end", 32'(busy_a), 32'h0);
        chk("t1_pi_hold",  32'(pi_a),   32'h7F);
        chk_a("t1", 0, 0, 0, 0, 0);

        // T2: LSB flipped everywhere, started from DONE
        mode = 2'd1;
        pulse_a();
        chk("t2_done_clr", 32'(done_a), 32'h0);
        wait_done_a(n);
        chk("t2_lat", 32'(n), 32'd128);
        chk_a("t2", 128, 128, 128, 1, 0);

        // T3: single 4-bit error at 0x5A
        mode = 2'd2;
        pulse_a();
        wait_done_a(n);
        chk_a("t3", 1, 4, 15, 4, 'h5A);

        // T4: pipelined partition, same stimulus as T3
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("t4_busy", 32'(busy_b), 32'h1);
        n = 0;
        while (done_b !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("t4_lat", 32'(n), 32'd130);
        chk("t4_err", 32'(err_b), 32'd1);
        chk("t4_hd",  32'(hd_b),  32'd4);
        chk("t4_aed", 32'(aed_b), 32'd15);
        chk("t4_max", 32'(mx_b),  32'd4);
        chk("t4_wv",  32'(wv_b),  32'h5A);

        // T6: start mid-sweep is ignored
        mode = 2'd1;
        pulse_a();
        repeat (16) tick();
        chk("t6_pi10", 32'(pi_a), 32'h10);
        pulse_a();
        chk("t6_no_restart", 32'(pi_a), 32'h11);
        wait_done_a(n);
        chk("t6_lat", 32'(n + 17), 32'd128);
        chk_a("t6", 128, 128, 128, 1, 0);

        // T5: reset mid-sweep, then a clean re-run
        pulse_a();
        repeat (64) tick();
        chk("t5_pi40", 32'(pi_a), 32'h40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", 32'(busy_a), 32'h0);
        chk("t5_pi",   32'(pi_a),   32'h0);
        chk_a("t5_rst", 0, 0, 0, 0, 0);
        pulse_a();
        wait_done_a(n);
        chk("t5_lat", 32'(n), 32'd128);
        chk_a("t5", 128, 128, 128, 1, 0);

        // start with rst: reset wins
        rst = 1'b1;
        pulse_a();
        rst = 1'b0;
        chk("rs_busy", 32'(busy_a), 32'h0);
        chk("rs_done", 32'(done_a), 32'h0);
        chk("rs_err",  32'(err_a),  32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
